shoe_datapath: RTL and testbench
================================

Name: shoe_datapath

Overview:
- Next-generation baccarat card datapath. Replaces free-running deal-on-load with a request/acknowledge deal engine drawing from a finite multi-deck shoe.
- Holds a parametrised number of card slots per hand for the player and the dealer, and keeps per-rank remaining counts so no rank is overdrawn.
- Produces baccarat hand scores and flat card buses for the display and controller logic.
- Sits between the round state machine (master of the deal handshake) and the 7-segment display stage.

Parameters:
- NUM_DECKS, 1, decks in shoe; legal 1..8; each rank starts with 4*NUM_DECKS cards.
- CARDS_PER_HAND, 3, slots per hand; legal 2..4.
- REM_W, $clog2(52*NUM_DECKS+1), width of the shoe remaining count.

Ports:
- slow_clock  in  1  sole clock; all state updates on the rising edge.
- resetb  in  1  synchronous, active-low reset.
- new_round  in  1  clears both hands; shoe counts retained.
- deal_valid  in  1  deal request.
- deal_hand  in  1  0=player, 1=dealer; sampled with deal_valid.
- deal_ready  out  1  engine can accept a request.
- deal_done  out  1  one-cycle completion pulse.
- deal_reject  out  1  qualifies deal_done: target hand was full, nothing dealt.
- card_out  out  4  card dealt; valid only while deal_done is high.
- rank_out  out  4  current rank counter (debug/verification).
- pcards  out  4*CARDS_PER_HAND  player slots; slot0 in LSBs; 0 = empty.
- dcards  out  4*CARDS_PER_HAND  dealer slots; same layout as pcards.
- pcount  out  3  cards held by the player.
- dcount  out  3  cards held by the dealer.
- pscore_out  out  4  player baccarat score.
- dscore_out  out  4  dealer baccarat score.
- shoe_remaining  out  REM_W  undealt cards in the shoe.
- shoe_empty  out  1  high when shoe_remaining==0.

Behaviour:
- Reset (resetb low at an edge): all slots, counts, scores 0; every rank count = 4*NUM_DECKS; shoe_remaining = 52*NUM_DECKS; FSM=IDLE; rank counter=1; deal_done, deal_reject, card_out = 0; deal_ready = 1. Reset overrides any in-flight deal.
- Rank counter: increments every cycle, 1..13, wraps 13->1. Runs in every state.
- deal_ready = (state==IDLE) && !shoe_empty && !new_round.
- FSM IDLE:
  - deal_valid && deal_ready at an edge captures deal_hand.
  - If that hand's count == CARDS_PER_HAND, go to DONE with reject.
  - Otherwise go to SEEK.
- FSM SEEK:
  - At each edge, if remaining[rank counter] > 0: write the rank into the hand's next slot (index = count), increment that count, decrement the rank count and shoe_remaining, latch card_out = rank, go to DONE.
  - Otherwise stay in SEEK; the counter moves on, so exhausted ranks are skipped.
  - SEEK terminates because entry requires !shoe_empty.
- FSM DONE: deal_done=1 for exactly one cycle, then IDLE.
  - card_out = dealt rank, or 0 with deal_reject=1.
- Latency: request accepted at edge E; card written at edge E+1 at the earliest; deal_done high in the cycle after that write.
- new_round (IDLE only; ignored in other states): at the edge, clear pcards, dcards, counts and scores. Shoe counts are untouched.
- Score: value = rank for ranks 1..9, 0 for ranks 10..13; score = (sum of hand values) mod 10, combinational from the slots. Sum width must hold 4*9 without overflow.
- Simultaneous new_round and deal_valid in IDLE: new_round wins, request not accepted (deal_ready is low).
- Shoe reaches 0: shoe_empty rises in the cycle after the final decrement; deal_ready is then low until reset.

Test Plan:
- Reset, then deal_valid=1, deal_hand=0 in the first cycle (rank_out=1) -> card 2 written to player slot0; deal_done pulses with card_out=2; pcount=1; pscore_out=2; shoe_remaining=51.
- Player hand built to 1,5,13 by timing requests against rank_out -> pcards slots 1/5/13; pscore_out=6.
- Dealer hand built to 2,8,7 -> dscore_out=7 (mod-10 wrap); HEX source dcards matches.
- With CARDS_PER_HAND=3, a 4th player request -> deal_done and deal_reject high together, card_out=0, pcount stays 3, shoe_remaining unchanged.
- NUM_DECKS=1: after four 2s are dealt, a SEEK sampling rank 2 -> waits a cycle and deals 3; a later new_round clears both hands while shoe_remaining keeps its value.
- Deal all 52 cards across rounds -> shoe_empty=1, deal_ready=0, deal_valid ignored. Then resetb=0 for one edge -> shoe_remaining=52, all outputs 0.

Source files
------------

// File: rtl/shoe_datapath.sv
// rtl/shoe_datapath.sv - baccarat shoe deal engine with per-rank counts, hand slots and scores
module shoe_datapath #(
   parameter int NUM_DECKS      = 1,
   parameter int CARDS_PER_HAND = 3,
   parameter int REM_W          = $clog2(52*NUM_DECKS+1)
) (
   input  logic                        slow_clock,
   input  logic                        resetb,
   input  logic                        new_round,
   input  logic                        deal_valid,
   input  logic                        deal_hand,
   output logic                        deal_ready,
   output logic                        deal_done,
   output logic                        deal_reject,
   output logic [3:0]                  card_out,
   output logic [3:0]                  rank_out,
   output logic [4*CARDS_PER_HAND-1:0] pcards,
   output logic [4*CARDS_PER_HAND-1:0] dcards,
   output logic [2:0]                  pcount,
   output logic [2:0]                  dcount,
   output logic [3:0]                  pscore_out,
   output logic [3:0]                  dscore_out,
   output logic [REM_W-1:0]            shoe_remaining,
   output logic                        shoe_empty
);

   localparam int RC_W = $clog2(4*NUM_DECKS+1);
   localparam int SI_W = $clog2(CARDS_PER_HAND);
   localparam logic [RC_W-1:0]  RANK_INIT = RC_W'(4*NUM_DECKS);
   localparam logic [REM_W-1:0] SHOE_INIT = REM_W'(52*NUM_DECKS);
   localparam logic [2:0]       HAND_FULL = 3'(CARDS_PER_HAND);

   typedef enum logic [1:0] {IDLE, SEEK, DONE} state_e;

   state_e           state_q, state_d;
   logic [3:0]       rank_q, rank_d;
   logic             hand_q, hand_d;
   logic             reject_q, reject_d;
   logic [3:0]       card_q, card_d;
   logic [3:0]       pslot_q [CARDS_PER_HAND];
   logic [3:0]       pslot_d [CARDS_PER_HAND];
   logic [3:0]       dslot_q [CARDS_PER_HAND];
   logic [3:0]       dslot_d [CARDS_PER_HAND];
   logic [2:0]       pcnt_q, pcnt_d;
   logic [2:0]       dcnt_q, dcnt_d;
   logic [RC_W-1:0]  rem_q [13];
   logic [RC_W-1:0]  rem_d [13];
   logic [REM_W-1:0] shoe_q, shoe_d;

   logic [3:0]       rank_idx;
   logic             rank_avail;
   logic [2:0]       tgt_cnt;
   logic [5:0]       psum, dsum;

   assign rank_idx   = rank_q - 4'd1;
   assign rank_avail = (rem_q[rank_idx] != '0);
   assign tgt_cnt    = deal_hand ? dcnt_q : pcnt_q;

   assign shoe_empty     = (shoe_q == '0);
   assign shoe_remaining = shoe_q;
   assign deal_ready     = (state_q == IDLE) && !shoe_empty && !new_round;
   assign deal_done      = (state_q == DONE);
   assign deal_reject    = deal_done && reject_q;
   assign card_out       = deal_done ? card_q : 4'd0;
   assign rank_out       = rank_q;
   assign pcount         = pcnt_q;
   assign dcount         = dcnt_q;

   always_comb begin
      state_d  = state_q;
      rank_d   = (rank_q == 4'd13) ? 4'd1 : rank_q + 4'd1;
      hand_d   = hand_q;
      reject_d = reject_q;
      card_d   = card_q;
      pslot_d  = pslot_q;
      dslot_d  = dslot_q;
      pcnt_d   = pcnt_q;
      dcnt_d   = dcnt_q;
      rem_d    = rem_q;
      shoe_d   = shoe_q;
      case (state_q)
         IDLE: begin
            if (new_round) begin
               for (int i = 0; i < CARDS_PER_HAND; i++) begin
                  pslot_d[i] = 4'd0;
                  dslot_d[i] = 4'd0;
               end
               pcnt_d = 3'd0;
               dcnt_d = 3'd0;
            end else if (deal_valid && deal_ready) begin
               hand_d = deal_hand;
               if (tgt_cnt == HAND_FULL) begin
                  reject_d = 1'b1;
                  card_d   = 4'd0;
                  state_d  = DONE;
               end else begin
                  reject_d = 1'b0;
                  state_d  = SEEK;
               end
            end
         end
         // Exhausted ranks are skipped simply by letting the counter move on.
         SEEK: begin
            if (rank_avail) begin
               if (hand_q) begin
                  dslot_d[dcnt_q[SI_W-1:0]] = rank_q;
                  dcnt_d = dcnt_q + 3'd1;
               end else begin
                  pslot_d[pcnt_q[SI_W-1:0]] = rank_q;
                  pcnt_d = pcnt_q + 3'd1;
               end
               rem_d[rank_idx] = rem_q[rank_idx] - RC_W'(1);
               shoe_d  = shoe_q - REM_W'(1);
               card_d  = rank_q;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge slow_clock) begin
      if (!resetb) begin
         state_q  <= IDLE;
         rank_q   <= 4'd1;
         hand_q   <= 1'b0;
         reject_q <= 1'b0;
         card_q   <= 4'd0;
         pcnt_q   <= 3'd0;
         dcnt_q   <= 3'd0;
         shoe_q   <= SHOE_INIT;
         for (int i = 0; i < CARDS_PER_HAND; i++) begin
            pslot_q[i] <= 4'd0;
            dslot_q[i] <= 4'd0;
         end
         for (int r = 0; r < 13; r++) begin
            rem_q[r] <= RANK_INIT;
         end
      end else begin
         state_q  <= state_d;
         rank_q   <= rank_d;
         hand_q   <= hand_d;
         reject_q <= reject_d;
         card_q   <= card_d;
         pcnt_q   <= pcnt_d;
         dcnt_q   <= dcnt_d;
         shoe_q   <= shoe_d;
         pslot_q  <= pslot_d;
         dslot_q  <= dslot_d;
         rem_q    <= rem_d;
      end
   end

   // Face cards and tens score zero; the sum stays wide enough for four nines.
   always_comb begin
      psum   = 6'd0;
      dsum   = 6'd0;
      pcards = '0;
      dcards = '0;
      for (int i = 0; i < CARDS_PER_HAND; i++) begin
         pcards[4*i +: 4] = pslot_q[i];
         dcards[4*i +: 4] = dslot_q[i];
         if (pslot_q[i] <= 4'd9) psum = psum + {2'b00, pslot_q[i]};
         if (dslot_q[i] <= 4'd9) dsum = dsum + {2'b00, dslot_q[i]};
      end
   end

   assign pscore_out = 4'(psum % 6'd10);
   assign dscore_out = 4'(dsum % 6'd10);

endmodule

// File: tb/tb_shoe_datapath.sv
// tb/tb_shoe_datapath.sv - scoreboard bench for shoe_datapath
module tb_shoe_datapath;
   localparam int ND  = 1;
   localparam int CPH = 3;
   localparam int RW  = $clog2(52*ND+1);

   logic             clk = 1'b0;
   logic             resetb, new_round, deal_valid, deal_hand;
   logic             deal_ready, deal_done, deal_reject, shoe_empty;
   logic [3:0]       card_out, rank_out, pscore_out, dscore_out;
   logic [4*CPH-1:0] pcards, dcards;
   logic [2:0]       pcount, dcount;
   logic [RW-1:0]    shoe_remaining;

   always #5 clk = ~clk;

   shoe_datapath #(.NUM_DECKS(ND), .CARDS_PER_HAND(CPH), .REM_W(RW)) dut (
      .slow_clock(clk), .resetb(resetb), .new_round(new_round),
      .deal_valid(deal_valid), .deal_hand(deal_hand), .deal_ready(deal_ready),
      .deal_done(deal_done), .deal_reject(deal_reject), .card_out(card_out),
      .rank_out(rank_out), .pcards(pcards), .dcards(dcards), .pcount(pcount),
      .dcount(dcount), .pscore_out(pscore_out), .dscore_out(dscore_out),
      .shoe_remaining(shoe_remaining), .shoe_empty(shoe_empty)
   );

   typedef struct {int card; bit rej;} exp_t;
   exp_t sb[$];

   int vectors = 0, miscompares = 0;
   int m_rank;
   int mhand[2][CPH];
   int mcnt[2];
   int mrem[14];
   int mshoe;

   always @(posedge clk) begin
      if (!resetb) m_rank <= 1;
      else         m_rank <= (m_rank == 13) ? 1 : m_rank + 1;
   end

   task automatic check_eq(input string tag, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
      end
   endtask

   function automatic int next_rank(input int r);
      return (r == 13) ? 1 : r + 1;
   endfunction

   function automatic int prev_rank(input int r);
      return (r == 1) ? 13 : r - 1;
   endfunction

   function automatic int m_score(input int h);
      int s = 0;
      for (int i = 0; i < mcnt[h]; i++) s += (mhand[h][i] <= 9) ? mhand[h][i] : 0;
      return s % 10;
   endfunction

   function automatic int m_flat(input int h);
      int f = 0;
      for (int i = 0; i < mcnt[h]; i++) f |= mhand[h][i] << (4*i);
      return f;
   endfunction

   function automatic void clear_hands();
      for (int h = 0; h < 2; h++) begin
         mcnt[h] = 0;
         for (int i = 0; i < CPH; i++) mhand[h][i] = 0;
      end
   endfunction

   task automatic check_state(input string tag);
      check_eq({tag, ".pcount"}, pcount, mcnt[0]);
      check_eq({tag, ".dcount"}, dcount, mcnt[1]);
      check_eq({tag, ".pcards"}, pcards, m_flat(0));
      check_eq({tag, ".dcards"}, dcards, m_flat(1));
      check_eq({tag, ".pscore"}, pscore_out, m_score(0));
      check_eq({tag, ".dscore"}, dscore_out, m_score(1));
      check_eq({tag, ".shoe_rem"}, shoe_remaining, mshoe);
      check_eq({tag, ".shoe_empty"}, shoe_empty, (mshoe == 0) ? 1 : 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetb = 1'b0; new_round = 1'b0; deal_valid = 1'b0;
      repeat (2) @(negedge clk);
      resetb = 1'b1;
      clear_hands();
      for (int r = 1; r <= 13; r++) mrem[r] = 4*ND;
      mshoe = 52*ND;
      check_eq("rst.rank_out", rank_out, 1);
      check_eq("rst.deal_ready", deal_ready, 1);
      check_eq("rst.deal_done", deal_done, 0);
      check_eq("rst.deal_reject", deal_reject, 0);
      check_eq("rst.card_out", card_out, 0);
      check_state("rst");
   endtask

   // Called at a negedge; with target!=0 the request is timed so SEEK first samples that rank.
   task automatic deal(input bit h, input int target);
      int   g, r;
      exp_t e;
      g = 0;
      while (target != 0 && m_rank != prev_rank(target) && g < 40) begin
         @(negedge clk);
         g++;
      end
      deal_hand = h; deal_valid = 1'b1;
      #1;
      check_eq("deal.ready", deal_ready, 1);
      check_eq("deal.rank_out", rank_out, m_rank);
      if (mcnt[h] == CPH) begin
         e.rej = 1'b1; e.card = 0;
      end else begin
         r = next_rank(m_rank);
         g = 0;
         while (mrem[r] == 0 && g < 13) begin r = next_rank(r); g++; end
         e.rej = 1'b0; e.card = r;
         mhand[h][mcnt[h]] = r;
         mcnt[h]++; mrem[r]--; mshoe--;
      end
      sb.push_back(e);
      @(posedge clk);
      #1 deal_valid = 1'b0;
      @(negedge clk);
      g = 0;
      while (!deal_done && g < 40) begin @(negedge clk); g++; end
      check_eq("deal.done_in_time", (g < 40) ? 1 : 0, 1);
      e = sb.pop_front();
      check_eq("deal.card_out", card_out, e.card);
      check_eq("deal.reject", deal_reject, e.rej);
      check_state("deal");
      @(negedge clk);
      check_eq("deal.done_one_cycle", deal_done, 0);
   endtask

   task automatic start_round();
      new_round = 1'b1;
      #1;
      check_eq("nr.ready_low", deal_ready, 0);
      @(posedge clk);
      #1 new_round = 1'b0;
      clear_hands();
      @(negedge clk);
      check_state("new_round");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int h, g, seen;
      resetb = 1'b0; new_round = 1'b0; deal_valid = 1'b0; deal_hand = 1'b0;
      do_reset();

      deal(0, 2);
      check_eq("first.pscore", pscore_out, 2);
      check_eq("first.shoe", shoe_remaining, 51);

      new_round = 1'b1; deal_valid = 1'b1; deal_hand = 1'b0;
      @(posedge clk);
      #1 new_round = 1'b0; deal_valid = 1'b0;
      clear_hands();
      seen = 0;
      repeat (3) begin @(negedge clk); if (deal_done) seen++; end
      check_eq("nr_wins.no_deal", seen, 0);
      check_state("nr_wins");

      deal(0, 1); deal(0, 5); deal(0, 13);
      check_eq("p1513.pcards", pcards, 12'hD51);
      check_eq("p1513.pscore", pscore_out, 6);
      deal(0, 0);
      check_eq("full.pcount", pcount, 3);
      check_eq("full.shoe", shoe_remaining, 48);

      deal(1, 2); deal(1, 8); deal(1, 7);
      check_eq("d287.dcards", dcards, 12'h782);
      check_eq("d287.dscore", dscore_out, 7);

      start_round();
      deal(0, 2); deal(0, 2); deal(0, 2);
      check_eq("skip2.pcards", pcards, 12'h322);
      start_round();
      check_eq("keep.shoe", shoe_remaining, 42);

      h = 0; g = 0;
      while (mshoe > 0 && g < 200) begin
         if (mcnt[h] == CPH) start_round();
         deal(h[0], 0);
         h = 1 - h; g++;
      end
      check_eq("empty.shoe_empty", shoe_empty, 1);
      check_eq("empty.shoe_rem", shoe_remaining, 0);
      check_eq("empty.ready", deal_ready, 0);
      deal_valid = 1'b1; seen = 0;
      repeat (20) begin @(negedge clk); if (deal_done) seen++; end
      deal_valid = 1'b0;
      check_eq("empty.ignored", seen, 0);
      check_eq("empty.ready_still_low", deal_ready, 0);

      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
